// File: rtl/icache_ctrl.sv
// icache_ctrl: 2-way icache tag/valid/LRU control with single-beat refill and uncached path; ICACHE_PERF_EN adds hit/miss counters
module icache_ctrl #(
  parameter int          TAG_W      = 55,
  parameter logic [63:0] CACHE_BASE = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_e,
  input  logic [63:0] sram_addr,
  input  logic        fence_i,
  output logic [1:0]  hit_o,
  output logic        lru_o,
  output logic        cache_o,
  output logic        refresh_o,
  output logic [63:0] cacheline_new_o,
  output logic        busy_o,
  output logic        unc_valid_o,
  output logic [63:0] unc_rdata_o,
  output logic        err_o,
`ifdef ICACHE_PERF_EN
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o,
`endif
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  output logic [63:0] ar_addr_o,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  input  logic [63:0] r_data_i,
  input  logic [1:0]  r_resp_i
);
  typedef enum logic [2:0] {IDLE, AR, R, REFILL, UNC} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, data_q, data_d;
  logic cached_q, cached_d, vic_q, vic_d, fence_q, fence_d, err_q, err_d;
  logic [1:0][63:0] valid_q, valid_d;
  logic [63:0] lru_q, lru_d;
  logic [TAG_W-1:0] tag_q [2][64];
  logic [5:0] idx, ridx;
  logic idle, vic, clr;
  logic [31:0] word;
  assign idx = sram_addr[8:3];
  assign ridx = addr_q[8:3];
  assign idle = state_q == IDLE;
  assign cache_o = sram_addr >= CACHE_BASE;
  // a fence in the same cycle must not let a stale line report a hit
  for (genvar w = 0; w < 2; w++) begin : g_hit
    assign hit_o[w] = idle & sram_e & cache_o & ~fence_i & valid_q[w][idx] & (tag_q[w][idx] == sram_addr[63:9]);
  end
  assign vic = ~valid_q[0][idx] ? 1'b0 : ~valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign lru_o = idle ? vic : vic_q;
  assign busy_o = ~idle;
  assign refresh_o = state_q == REFILL;
  assign cacheline_new_o = refresh_o ? data_q : '0;
  assign unc_valid_o = state_q == UNC;
  assign word = addr_q[2:0] == 3'd4 ? data_q[63:32] : addr_q[2:0] == 3'd0 ? data_q[31:0] : '0;
  assign unc_rdata_o = unc_valid_o ? {32'b0, word} : '0;
  assign err_o = err_q;
  assign ar_valid_o = state_q == AR;
  assign ar_addr_o = ar_valid_o ? {addr_q[63:3], 3'b0} : '0;
  assign r_ready_o = state_q == R;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    cached_d = cached_q;
    vic_d = vic_q;
    err_d = 1'b0;
    valid_d = valid_q;
    lru_d = lru_q;
    case (state_q)
      IDLE: begin
        if (|hit_o) lru_d[idx] = hit_o[0];
        if (sram_e & ~|hit_o) begin
          state_d = AR;
          addr_d = sram_addr;
          cached_d = cache_o;
          vic_d = vic;
        end
      end
      AR: if (ar_ready_i) state_d = R;
      R: if (r_valid_i) begin
        data_d = r_data_i;
        err_d = |r_resp_i;
        state_d = |r_resp_i ? IDLE : cached_q ? REFILL : UNC;
      end
      REFILL: begin
        valid_d[vic_q][ridx] = 1'b1;
        lru_d[ridx] = ~vic_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a fence seen mid-transaction is held until the return to IDLE
    clr = idle ? fence_i : (state_d == IDLE) & (fence_i | fence_q);
    fence_d = ~idle & (state_d != IDLE) & (fence_i | fence_q);
    if (clr) valid_d = '0;
  end
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;
  assign perf_hit_d = perf_hit_q + {31'b0, |hit_o};
  assign perf_miss_d = perf_miss_q + {31'b0, idle & (state_d == AR) & cache_o};
  assign perf_hit_o = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_q <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      cached_q <= 1'b0;
      vic_q <= 1'b0;
      fence_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= '0;
      lru_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cached_q <= cached_d;
      vic_q <= vic_d;
      fence_q <= fence_d;
      err_q <= err_d;
      valid_q <= valid_d;
      lru_q <= lru_d;
    end
  end
  always_ff @(posedge clk) begin
    if (refresh_o) tag_q[vic_q][ridx] <= addr_q[63:9];
  end
endmodule
